// File: rtl/hb_xcel_pkg.sv
// Shared definitions for the vector add-copy accelerator tile:
// CSR indices, FSM state encoding, memory op codes and a byte-mask helper.
package hb_xcel_pkg;

  localparam logic [2:0] CSR_GO     = 3'd0;
  localparam logic [2:0] CSR_SRC    = 3'd1;
  localparam logic [2:0] CSR_DST    = 3'd2;
  localparam logic [2:0] CSR_COUNT  = 3'd3;
  localparam logic [2:0] CSR_ADDEND = 3'd4;
  localparam logic [2:0] CSR_CYCLES = 3'd5;

  localparam logic LOAD  = 1'b0;
  localparam logic STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LD   = 2'd1,
    WAIT = 2'd2,
    ST   = 2'd3
  } state_t;

  // Merge write data into an existing register, one byte per mask bit.
  function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = mask[b] ? wr_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hb_xcel_csr.sv
// CSR file for the accelerator: byte-masked config registers, GO decode,
// registered slave response and, when HB_XCEL_CYCLE_CNT_EN is defined,
// a read-only busy-cycle counter at CSR 5.
module hb_xcel_csr
  import hb_xcel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] slave_addr,
  input  logic [31:0] slave_data,
  input  logic [3:0]  slave_mask,
  input  logic        slave_type,
  input  logic        slave_val,
  output logic        slave_yum,
  output logic [31:0] slave_ret_data,
  output logic        slave_ret_val,
  input  logic        busy,
  input  logic        done,
  output logic        go,
  output logic [31:0] src,
  output logic [31:0] dst,
  output logic [31:0] count,
  output logic [31:0] addend
);

  logic [2:0]  csr_idx;
  logic        wr_en;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign csr_idx     = slave_addr[2:0];
  assign unused_addr = ^slave_addr[31:3];
  assign slave_yum   = slave_val;
  // Config writes and GO are dropped while a run is active, but still answered.
  assign wr_en       = slave_val && slave_type && !busy;
  assign go          = wr_en && (csr_idx == CSR_GO) && slave_data[0];

`ifdef HB_XCEL_CYCLE_CNT_EN
  logic [31:0] cycles;

  // Busy-cycle counter, restarted by each accepted GO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else if (go) begin
      cycles <= '0;
    end else if (busy) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

  // Config registers with bytewise write masking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src    <= '0;
      dst    <= '0;
      count  <= '0;
      addend <= '0;
    end else if (wr_en) begin
      case (csr_idx)
        CSR_SRC:    src    <= apply_mask(src,    slave_data, slave_mask);
        CSR_DST:    dst    <= apply_mask(dst,    slave_data, slave_mask);
        CSR_COUNT:  count  <= apply_mask(count,  slave_data, slave_mask);
        CSR_ADDEND: addend <= apply_mask(addend, slave_data, slave_mask);
        default: ;
      endcase
    end
  end

  // Read mux over current (pre-write) register values.
  always_comb begin
    rd_data = '0;
    case (csr_idx)
      CSR_GO:     rd_data = {30'd0, done, busy};
      CSR_SRC:    rd_data = src;
      CSR_DST:    rd_data = dst;
      CSR_COUNT:  rd_data = count;
      CSR_ADDEND: rd_data = addend;
`ifdef HB_XCEL_CYCLE_CNT_EN
      CSR_CYCLES: rd_data = cycles;
`endif
      default:    rd_data = '0;
    endcase
  end

  // One-cycle registered response to every accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slave_ret_val  <= 1'b0;
      slave_ret_data <= '0;
    end else begin
      slave_ret_val  <= slave_val;
      slave_ret_data <= (slave_val && !slave_type) ? rd_data : 32'd0;
    end
  end

endmodule

// File: rtl/hb_ifc_mem_xcel.sv
// Vector add-copy accelerator tile: dst[i] = src[i] + addend for count words.
// Optional busy-cycle counter at CSR 5 is enabled by HB_XCEL_CYCLE_CNT_EN.
//
// state | meaning
// IDLE  | waiting for GO; done/busy reported through STATUS
// LD    | load request for element i on the master port
// WAIT  | waiting for the load response tagged with i[10:0]
// ST    | store request of result for element i
module hb_ifc_mem_xcel
  import hb_xcel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] slave_addr,
  input  logic [31:0] slave_data,
  input  logic [3:0]  slave_mask,
  input  logic        slave_type,
  input  logic        slave_val,
  output logic        slave_yum,
  output logic [31:0] slave_ret_data,
  output logic        slave_ret_val,
  output logic        master_val,
  output logic        master_type,
  output logic [31:0] master_addr,
  output logic [10:0] master_opq,
  output logic [31:0] master_data,
  output logic [3:0]  master_mask,
  input  logic        master_rdy,
  input  logic [31:0] master_ret_data,
  input  logic [10:0] master_ret_opq,
  input  logic        master_ret_val
);

  state_t      state, state_nxt;
  logic [31:0] idx, idx_inc, result;
  logic        done, busy, go, ret_hit;
  logic [31:0] src, dst, count, addend;

  assign busy    = (state != IDLE);
  assign idx_inc = idx + 32'd1;
  assign ret_hit = master_ret_val && (master_ret_opq == idx[10:0]);

  hb_xcel_csr u_csr (
    .clk            (clk),
    .reset          (reset),
    .slave_addr     (slave_addr),
    .slave_data     (slave_data),
    .slave_mask     (slave_mask),
    .slave_type     (slave_type),
    .slave_val      (slave_val),
    .slave_yum      (slave_yum),
    .slave_ret_data (slave_ret_data),
    .slave_ret_val  (slave_ret_val),
    .busy           (busy),
    .done           (done),
    .go             (go),
    .src            (src),
    .dst            (dst),
    .count          (count),
    .addend         (addend)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go && (count != 32'd0)) state_nxt = LD;
      LD:   if (master_rdy) state_nxt = WAIT;
      WAIT: if (ret_hit) state_nxt = ST;
      ST:   if (master_rdy) state_nxt = (idx_inc == count) ? IDLE : LD;
      default: state_nxt = IDLE;
    endcase
  end

  // Element index, load result and completion flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            idx  <= '0;
            done <= (count == 32'd0);
          end
        end
        WAIT: begin
          if (ret_hit) result <= master_ret_data + addend;
        end
        ST: begin
          if (master_rdy) begin
            idx <= idx_inc;
            if (idx_inc == count) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Master request outputs decoded from registered state; CSRs are frozen
  // while busy so the request holds steady until accepted.
  always_comb begin
    master_val  = 1'b0;
    master_type = LOAD;
    master_addr = '0;
    master_opq  = '0;
    master_data = '0;
    master_mask = 4'h0;
    case (state)
      LD: begin
        master_val  = 1'b1;
        master_type = LOAD;
        master_addr = src + {idx[29:0], 2'b00};
        master_opq  = idx[10:0];
        master_mask = 4'hF;
      end
      ST: begin
        master_val  = 1'b1;
        master_type = STORE;
        master_addr = dst + {idx[29:0], 2'b00};
        master_data = result;
        master_mask = 4'hF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hb_ifc_mem_xcel.sv
`timescale 1ns/1ps
module tb_hb_ifc_mem_xcel;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] slave_addr, slave_data, slave_ret_data;
  logic [3:0]  slave_mask;
  logic        slave_type, slave_val, slave_yum, slave_ret_val;
  logic        master_val, master_type, master_rdy, master_ret_val;
  logic [31:0] master_addr, master_data, master_ret_data;
  logic [10:0] master_opq, master_ret_opq;
  logic [3:0]  master_mask;

  hb_ifc_mem_xcel dut (
    .clk             (clk),
    .reset           (reset),
    .slave_addr      (slave_addr),
    .slave_data      (slave_data),
    .slave_mask      (slave_mask),
    .slave_type      (slave_type),
    .slave_val       (slave_val),
    .slave_yum       (slave_yum),
    .slave_ret_data  (slave_ret_data),
    .slave_ret_val   (slave_ret_val),
    .master_val      (master_val),
    .master_type     (master_type),
    .master_addr     (master_addr),
    .master_opq      (master_opq),
    .master_data     (master_data),
    .master_mask     (master_mask),
    .master_rdy      (master_rdy),
    .master_ret_data (master_ret_data),
    .master_ret_opq  (master_ret_opq),
    .master_ret_val  (master_ret_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        typ;
    logic [31:0] addr;
    logic [10:0] opq;
    logic [31:0] data;
  } req_t;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [31:0] mem_q[$];
  req_t        obs_q[$];
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One slave transaction, started at a negedge and finished at the next one.
  task automatic slave_op(input logic wr, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] m, output logic [31:0] rdata);
    logic [31:0] r;
    r = $urandom;
    slave_val  = 1'b1;
    slave_type = wr;
    slave_addr = {r[31:3], a};
    slave_data = d;
    slave_mask = m;
    #1 check("slave_yum", 32'(slave_yum), 32'd1);
    @(negedge clk);
    slave_val  = 1'b0;
    slave_type = 1'b0;
    slave_data = '0;
    slave_mask = '0;
    check("slave_ret_val", 32'(slave_ret_val), 32'd1);
    rdata = slave_ret_data;
    if (wr) check("slave_wr_ret_data", slave_ret_data, 32'd0);
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] dummy;
    slave_op(1'b1, a, d, m, dummy);
  endtask

  task automatic csr_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    slave_op(1'b0, a, $urandom, 4'hF, rd);
    check(tag, rd, exp);
  endtask

  // Program a run, drive a randomized memory with random rdy and stray
  // responses, then compare the observed request stream with the list the
  // operation should produce.
  task automatic run_vec(input logic [31:0] src, input logic [31:0] dst,
                         input logic [31:0] cnt, input logic [31:0] add,
                         input bit stall, input bit midrun);
    req_t        exp_q[$];
    req_t        r;
    int          due, due_idx, cyc, stall_left, n_ld, n_st;
    bit          hold, exp_ret;
    logic [31:0] exp_ret_data, h_addr, h_data;
    logic        h_typ;
    logic [10:0] h_opq;

    obs_q.delete();
    for (int k = 0; k < int'(cnt); k++) begin
      r.typ = 1'b0; r.addr = src + 32'(4 * k); r.opq = 11'(k); r.data = '0;
      exp_q.push_back(r);
      r.typ = 1'b1; r.addr = dst + 32'(4 * k); r.opq = '0; r.data = mem_q[k] + add;
      exp_q.push_back(r);
    end

    csr_wr(3'd1, src, 4'hF);
    csr_wr(3'd2, dst, 4'hF);
    csr_wr(3'd3, cnt, 4'hF);
    csr_wr(3'd4, add, 4'hF);
    csr_wr(3'd0, 32'd1, 4'hF);

    due = -1; due_idx = 0; cyc = 0; n_ld = 0; n_st = 0;
    stall_left = stall ? 5 : 0;
    hold = 1'b0; exp_ret = 1'b0; exp_ret_data = '0;
    h_typ = 1'b0; h_addr = '0; h_data = '0; h_opq = '0;

    while (n_st < int'(cnt) && cyc < 2000) begin
      if (hold) begin
        check("hold_val",  32'(master_val), 32'd1);
        check("hold_type", 32'(master_type), 32'(h_typ));
        check("hold_addr", master_addr, h_addr);
        check("hold_data", master_data, h_data);
        check("hold_opq",  32'(master_opq), 32'(h_opq));
      end
      if (exp_ret) begin
        check("busy_ret_val",  32'(slave_ret_val), 32'd1);
        check("busy_ret_data", slave_ret_data, exp_ret_data);
        exp_ret = 1'b0;
      end
      slave_val = 1'b0; slave_type = 1'b0;
      if (midrun) begin
        case (cyc)
          1: begin
            slave_val = 1'b1; slave_type = 1'b1; slave_addr = 32'd3;
            slave_data = 32'hFFFF_FFFF; slave_mask = 4'hF;
            exp_ret = 1'b1; exp_ret_data = 32'd0;
          end
          2: begin
            slave_val = 1'b1; slave_type = 1'b0; slave_addr = 32'd0;
            exp_ret = 1'b1; exp_ret_data = 32'd1;
          end
          3: begin
            slave_val = 1'b1; slave_type = 1'b1; slave_addr = 32'd0;
            slave_data = 32'd1; slave_mask = 4'hF;
            exp_ret = 1'b1; exp_ret_data = 32'd0;
          end
          default: ;
        endcase
      end

      if (master_val && stall_left > 0) begin
        master_rdy = 1'b0;
        stall_left--;
      end else begin
        master_rdy = ($urandom_range(0, 3) != 0);
      end
      hold = master_val && !master_rdy;
      h_typ = master_type; h_addr = master_addr; h_data = master_data; h_opq = master_opq;

      if (master_val && master_rdy) begin
        r.typ = master_type; r.addr = master_addr; r.opq = master_opq; r.data = master_data;
        obs_q.push_back(r);
        check("req_mask", 32'(master_mask), 32'hF);
        if (master_type == 1'b0) begin
          due = $urandom_range(1, 4);
          due_idx = n_ld;
          n_ld++;
        end else begin
          n_st++;
        end
      end

      master_ret_val  = 1'b0;
      master_ret_opq  = 11'($urandom);
      master_ret_data = $urandom;
      if (due == 0) begin
        master_ret_val  = 1'b1;
        master_ret_opq  = 11'(due_idx);
        master_ret_data = (due_idx < mem_q.size()) ? mem_q[due_idx] : 32'd0;
        due = -1;
      end else begin
        if (due > 0) due--;
        if ($urandom_range(0, 2) == 0) begin
          master_ret_val = 1'b1;
          master_ret_opq = 11'(n_ld + 2);
        end
      end
      @(negedge clk);
      cyc++;
    end

    master_rdy = 1'b0; master_ret_val = 1'b0; slave_val = 1'b0;
    check("run_stores", 32'(n_st), cnt);
    check("idle_after_run", 32'(master_val), 32'd0);
    check("req_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      check("req_type", 32'(obs_q[k].typ), 32'(exp_q[k].typ));
      check("req_addr", obs_q[k].addr, exp_q[k].addr);
      if (exp_q[k].typ) check("st_data", obs_q[k].data, exp_q[k].data);
      else              check("ld_opq", 32'(obs_q[k].opq), 32'(exp_q[k].opq));
    end
    csr_chk("status_after_run", 3'd0, 32'd2);
    csr_chk("count_kept", 3'd3, cnt);
`ifdef HB_XCEL_CYCLE_CNT_EN
    csr_chk("cycles", 3'd5, 32'(cyc));
`else
    csr_chk("cycles_absent", 3'd5, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] cnt;

    reset = 1'b1;
    slave_addr = '0; slave_data = '0; slave_mask = '0; slave_type = 1'b0; slave_val = 1'b0;
    master_rdy = 1'b0; master_ret_val = 1'b0; master_ret_opq = '0; master_ret_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_master_val",  32'(master_val), 32'd0);
    check("rst_master_addr", master_addr, 32'd0);
    check("rst_master_data", master_data, 32'd0);
    check("rst_master_opq",  32'(master_opq), 32'd0);
    check("rst_slave_ret",   32'(slave_ret_val), 32'd0);
    check("rst_slave_data",  slave_ret_data, 32'd0);

    // First read: response only in the following cycle, for exactly one cycle.
    slave_val = 1'b1; slave_type = 1'b0; slave_addr = 32'd0;
    #1 check("first_rd_no_early_ret", 32'(slave_ret_val), 32'd0);
    @(negedge clk);
    slave_val = 1'b0;
    check("first_rd_ret_val", 32'(slave_ret_val), 32'd1);
    check("first_rd_data", slave_ret_data, 32'd0);
    @(negedge clk);
    check("first_rd_ret_pulse", 32'(slave_ret_val), 32'd0);

    csr_wr(3'd1, 32'hAABB_CCDD, 4'b0011);
    csr_chk("src_masked", 3'd1, 32'h0000_CCDD);
    csr_wr(3'd6, 32'h1234_5678, 4'hF);
    csr_chk("csr6_zero", 3'd6, 32'd0);
    csr_chk("csr7_zero", 3'd7, 32'd0);
    csr_chk("status_after_rst", 3'd0, 32'd0);

    // Zero-length run completes immediately without memory traffic.
    csr_wr(3'd3, 32'd0, 4'hF);
    csr_wr(3'd0, 32'd1, 4'hF);
    check("cnt0_no_val", 32'(master_val), 32'd0);
    csr_chk("cnt0_status", 3'd0, 32'd2);
    check("cnt0_no_val_later", 32'(master_val), 32'd0);

    mem_q = '{32'd7, 32'd9};
    run_vec(32'h1000, 32'h2000, 32'd2, 32'd5, 1'b1, 1'b1);

    for (int t = 0; t < 4; t++) begin
      cnt = 32'($urandom_range(1, 6));
      mem_q.delete();
      for (int k = 0; k < int'(cnt); k++) mem_q.push_back($urandom);
      run_vec($urandom, $urandom, cnt, (t == 0) ? 32'hFFFF_FFF0 : $urandom,
              t[0], cnt >= 32'd2);
    end

    // Reset while waiting for a load response; the late response must be ignored.
    mem_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    csr_wr(3'd1, 32'h4000, 4'hF);
    csr_wr(3'd2, 32'h5000, 4'hF);
    csr_wr(3'd3, 32'd4, 4'hF);
    csr_wr(3'd4, 32'd3, 4'hF);
    csr_wr(3'd0, 32'd1, 4'hF);
    check("mid_ld_val", 32'(master_val), 32'd1);
    master_rdy = 1'b1;
    @(negedge clk);
    check("mid_wait_no_val", 32'(master_val), 32'd0);
    reset = 1'b1;
    #1 check("mid_rst_val", 32'(master_val), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    master_ret_val = 1'b1; master_ret_opq = 11'd0; master_ret_data = 32'd7;
    @(negedge clk);
    master_ret_val = 1'b0;
    for (int t = 0; t < 4; t++) begin
      check("post_rst_no_val", 32'(master_val), 32'd0);
      @(negedge clk);
    end
    master_rdy = 1'b0;
    csr_chk("post_rst_status", 3'd0, 32'd0);
    csr_chk("post_rst_src",    3'd1, 32'd0);
    csr_chk("post_rst_dst",    3'd2, 32'd0);
    csr_chk("post_rst_count",  3'd3, 32'd0);
    csr_chk("post_rst_addend", 3'd4, 32'd0);
    csr_chk("post_rst_cycles", 3'd5, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
